// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared encodings for the pipeline hazard controller: the two-state FSM
// (normal running / one-cycle load-use stall) and the PC source select codes
// that the fetch stage decodes.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_LSTALL = 1'b1
    } state_t;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_J   = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Bundles the execute-stage hazard inputs and the pipeline control outputs.
//   master modport : pipeline side, drives loadad/branch_ex/zero/jump_ex and
//                    receives the enables, flushes, bubble, pc_sel, forwarding
//                    enables (and the performance counters when present)
//   slave modport  : the hazard controller itself
// Build option: STALL_CNT_EN adds stall_cnt/flush_cnt of width CNT_W.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);

    logic       loadad;
    logic       branch_ex;
    logic       zero;
    logic       jump_ex;
    logic       pc_wr;
    logic       ifid_wr;
    logic       idex_wr;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exme_bubble;
    logic [1:0] pc_sel;
    logic       fwd_en_me;
    logic       fwd_en_re;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output loadad, branch_ex, zero, jump_ex,
        input  pc_wr, ifid_wr, idex_wr, ifid_flush, idex_flush, exme_bubble,
        input  pc_sel, fwd_en_me, fwd_en_re, stall_cnt, flush_cnt
    );

    modport slave (
        input  loadad, branch_ex, zero, jump_ex,
        output pc_wr, ifid_wr, idex_wr, ifid_flush, idex_flush, exme_bubble,
        output pc_sel, fwd_en_me, fwd_en_re, stall_cnt, flush_cnt
    );
`else
    // Counter width only matters when the counters exist.
    if (CNT_W < 1) begin : gCntWidthUnused
    end

    modport master (
        output loadad, branch_ex, zero, jump_ex,
        input  pc_wr, ifid_wr, idex_wr, ifid_flush, idex_flush, exme_bubble,
        input  pc_sel, fwd_en_me, fwd_en_re
    );

    modport slave (
        input  loadad, branch_ex, zero, jump_ex,
        output pc_wr, ifid_wr, idex_wr, ifid_flush, idex_flush, exme_bubble,
        output pc_sel, fwd_en_me, fwd_en_re
    );
`endif

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter
// Saturating up-counter used for the stall/flush performance counters.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears count
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count qualified events, holding at all-ones instead of wrapping so a
    // long run never reads back as a small number.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline control companion to the execute stage. Turns the load-use flag
// and branch/jump outcome into PC/IF-ID/ID-EX write enables, flushes and the
// EX/MEM bubble, and tracks per-stage valid bits from reset so forwarding
// paths only switch on once real instructions reach them.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : pipe_hazard_ctrl_if.slave (hazard inputs, control outputs)
// Parameters: CNT_W (counter width), FLUSH_SLOTS (1 = IF/ID, 2 = IF/ID + ID/EX)
// Build option: STALL_CNT_EN instantiates stall/flush saturating counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int FLUSH_SLOTS = 2
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    state_t state, nextState;
    logic   vId, vEx, vMe, vWb;
    logic   nextVId, nextVEx, nextVMe, nextVWb;
    logic   ldQ, redirect, redirectTaken;
    logic   pcWr, ifidWr, idexWr, ifidFlush, idexFlush, bubble;
    logic [1:0] pcSel;

    // A load-use hit needs both the consumer (EX) and the load (MEM) to be
    // real instructions. In LSTALL the load has moved on to WB and is
    // forwarded from there, so the flag is ignored.
    assign ldQ      = (state == ST_RUN) && bus.loadad && vEx && vMe;
    assign redirect = vEx && (bus.jump_ex || (bus.branch_ex && bus.zero));

    // State and valid bits are the only storage; reset clears them at once so
    // the forwarding enables drop without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            vId   <= 1'b0;
            vEx   <= 1'b0;
            vMe   <= 1'b0;
            vWb   <= 1'b0;
        end else begin
            state <= nextState;
            vId   <= nextVId;
            vEx   <= nextVEx;
            vMe   <= nextVMe;
            vWb   <= nextVWb;
        end
    end

    // Next-state and control outputs. A load-use stall wins over a redirect
    // because the branch operands in EX are stale that cycle; the branch is
    // re-evaluated in LSTALL with forwarded data. Otherwise the pipeline
    // simply advances and the valid bits shift down one stage.
    always_comb begin
        nextState     = ST_RUN;
        nextVId       = 1'b1;
        nextVEx       = vId;
        nextVMe       = vEx;
        nextVWb       = vMe;
        pcWr          = 1'b1;
        ifidWr        = 1'b1;
        idexWr        = 1'b1;
        ifidFlush     = 1'b0;
        idexFlush     = 1'b0;
        bubble        = 1'b0;
        pcSel         = PC_SEL_SEQ;
        redirectTaken = 1'b0;
        if (ldQ) begin
            pcWr      = 1'b0;
            ifidWr    = 1'b0;
            idexWr    = 1'b0;
            bubble    = 1'b1;
            nextState = ST_LSTALL;
            nextVId   = vId;
            nextVEx   = vEx;
            nextVMe   = 1'b0;
        end else if (redirect) begin
            redirectTaken = 1'b1;
            pcSel         = bus.jump_ex ? PC_SEL_J : PC_SEL_BR;
            ifidFlush     = 1'b1;
            idexFlush     = (FLUSH_SLOTS == 2);
            nextVId       = 1'b0;
            nextVEx       = (FLUSH_SLOTS == 2) ? 1'b0 : vId;
        end
    end

    assign bus.pc_wr       = pcWr;
    assign bus.ifid_wr     = ifidWr;
    assign bus.idex_wr     = idexWr;
    assign bus.ifid_flush  = ifidFlush;
    assign bus.idex_flush  = idexFlush;
    assign bus.exme_bubble = bubble;
    assign bus.pc_sel      = pcSel;
    assign bus.fwd_en_me   = vMe;
    assign bus.fwd_en_re   = vWb;

`ifdef STALL_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) uStallCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble),
        .count (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirectTaken),
        .count (bus.flush_cnt)
    );
`else
    // Counter width only matters when the counters exist.
    if (CNT_W < 1) begin : gCntWidthUnused
    end
`endif

endmodule
